hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Drives the IF/ID register's hold input (wait_ID), the PC write enable, the IF/ID flush and the ID/EX bubble/hold controls.
- Sequences three hazard sources: load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses.
- Sits between decode (ID), EX and the data-memory interface; purely a control block, no datapath storage.

Parameters:
REG_AW, 5, register-file address width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..4)
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (1..3)
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before timeout error (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-low
id_rs  in  REG_AW  source reg 1 of instruction in ID
id_rt  in  REG_AW  source reg 2 of instruction in ID
id_rs_used  in  1  ID instruction reads id_rs
id_rt_used  in  1  ID instruction reads id_rt
ex_rd  in  REG_AW  destination reg of instruction in EX
ex_mem_read  in  1  EX instruction is a load
branch_taken  in  1  EX resolved taken branch/jump this cycle
mem_busy  in  1  data memory not ready; pipeline must freeze
wait_ID  out  1  hold IF/ID register (1 = hold)
pc_wr_en  out  1  PC register write enable
flush_ID  out  1  load zero (NOP) into IF/ID instead of fetched IR
bubble_EX  out  1  load NOP into ID/EX
stall_EX  out  1  hold ID/EX, EX/MEM, MEM/WB registers
mem_timeout  out  1  sticky error: mem_busy exceeded MEM_TIMEOUT

Behaviour:
- Reset: synchronous, active-low; sampled only on rising clk. While reset==0 at an edge: state<=RUN, counters<=0, mem_timeout<=0. Reset mid-stall/flush/wait aborts it with no residual output.
- States: RUN, LD_STALL, FLUSH, MEM_WAIT. Control outputs are combinational decode of state + inputs (same-cycle response); mem_timeout is registered.
- Priority each cycle: mem_busy > branch_taken > load-use > normal.
- Load-use hit (lu): ex_mem_read && ex_rd!=0 && ((id_rs_used && id_rs==ex_rd) || (id_rt_used && id_rt==ex_rd)).
- RUN, no hazard: wait_ID=0, pc_wr_en=1, flush_ID=0, bubble_EX=0, stall_EX=0.
- RUN with lu: wait_ID=1, pc_wr_en=0, bubble_EX=1 this cycle. If LOAD_STALL_CYCLES>1: ->LD_STALL, cnt<=LOAD_STALL_CYCLES-2; else stay RUN.
- LD_STALL: same outputs as lu; cnt decrements; ->RUN when cnt==0 at edge. lu is not re-evaluated inside LD_STALL.
- branch_taken (RUN or LD_STALL): flush_ID=1, pc_wr_en=1 (PC loads target), bubble_EX=1, wait_ID=0. Overrides lu and cancels any LD_STALL. If FLUSH_CYCLES>1: ->FLUSH, cnt<=FLUSH_CYCLES-2; else ->RUN.
- FLUSH: flush_ID=1, pc_wr_en=1, bubble_EX=1, wait_ID=0; cnt decrements; ->RUN at cnt==0. branch_taken in FLUSH restarts count.
- mem_busy in any state: wait_ID=1, pc_wr_en=0, stall_EX=1, flush_ID=0, bubble_EX=0. Enter MEM_WAIT, saving interrupted state and cnt; branch_taken/lu ignored while mem_busy. On first cycle mem_busy==0 return to saved state with saved cnt; inputs then evaluated normally that cycle.
- Timeout counter: counts consecutive mem_busy cycles, saturates at MEM_TIMEOUT; on reaching MEM_TIMEOUT set mem_timeout=1 (sticky until reset). Counter clears when mem_busy==0. Freeze continues regardless of timeout.
- Invariants: flush_ID and wait_ID never both 1; stall_EX and bubble_EX never both 1.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_lu_cnt[31:0], perf_flush_cnt[31:0], perf_mem_cnt[31:0]; increment once per cycle with bubble_EX due to load-use, flush_ID==1, stall_EX==1 respectively; wrap at 2^32; cleared by reset.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 two cycles with mem_busy=1, branch_taken=1 -> after release all outputs in RUN defaults (pc_wr_en=1, others 0), mem_timeout=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_used=1, LOAD_STALL_CYCLES=2 -> wait_ID=1, bubble_EX=1, pc_wr_en=0 for exactly 2 cycles; same with ex_rd=0 -> no stall.
- Branch: branch_taken=1 one cycle, FLUSH_CYCLES=2 -> flush_ID=1, pc_wr_en=1, bubble_EX=1 for 2 cycles; branch during LD_STALL cancels stall.
- Mem freeze: mem_busy=1 during FLUSH with 1 cycle left, 4 cycles -> stall_EX=1, wait_ID=1 for 4 cycles, then 1 more flush cycle, then RUN.
- Timeout: MEM_TIMEOUT=8, mem_busy=1 for 10 cycles -> mem_timeout rises after 8th busy cycle, stays 1 after mem_busy drops until reset=0.
- Simultaneous: mem_busy=1, branch_taken=1, lu=1 same cycle -> freeze outputs only; no flush, no bubble.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flushes, data-memory freeze with timeout.
// Optional HAZARD_PERF_EN macro adds free-running performance counters.
module hazard_ctrl #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              wait_ID,
  output logic              pc_wr_en,
  output logic              flush_ID,
  output logic              bubble_EX,
  output logic              stall_EX,
  output logic              mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_lu_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_mem_cnt
`endif
);

  localparam int CNT_W = 2;
  localparam int TMO_W = 16;
  localparam logic [CNT_W-1:0] LD_RELOAD = CNT_W'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LD_STALL, FLUSH, MEM_WAIT} state_t;

  state_t             state_q, state_d, sav_state_q, sav_state_d, eff_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d, sav_cnt_q, sav_cnt_d, eff_cnt;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               lu;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

  // Leaving MEM_WAIT resumes the interrupted state as if the freeze never happened.
  assign eff_state = (state_q == MEM_WAIT) ? sav_state_q : state_q;
  assign eff_cnt   = (state_q == MEM_WAIT) ? sav_cnt_q   : cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sav_state_d = sav_state_q;
    sav_cnt_d   = sav_cnt_q;
    wait_ID     = 1'b0;
    pc_wr_en    = 1'b0;
    flush_ID    = 1'b0;
    bubble_EX   = 1'b0;
    stall_EX    = 1'b0;
    if (mem_busy) begin
      wait_ID  = 1'b1;
      stall_EX = 1'b1;
      state_d  = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        sav_state_d = state_q;
        sav_cnt_d   = cnt_q;
      end
    end else begin
      state_d = eff_state;
      cnt_d   = eff_cnt;
      if (branch_taken) begin
        flush_ID  = 1'b1;
        pc_wr_en  = 1'b1;
        bubble_EX = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FL_RELOAD;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        case (eff_state)
          LD_STALL: begin
            wait_ID   = 1'b1;
            bubble_EX = 1'b1;
            if (eff_cnt == '0) state_d = RUN;
            else               cnt_d   = eff_cnt - 1'b1;
          end
          FLUSH: begin
            flush_ID  = 1'b1;
            pc_wr_en  = 1'b1;
            bubble_EX = 1'b1;
            if (eff_cnt == '0) state_d = RUN;
            else               cnt_d   = eff_cnt - 1'b1;
          end
          default: begin
            state_d = RUN;
            if (lu) begin
              wait_ID   = 1'b1;
              bubble_EX = 1'b1;
              if (LOAD_STALL_CYCLES > 1) begin
                state_d = LD_STALL;
                cnt_d   = LD_RELOAD;
              end
            end else begin
              pc_wr_en = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    tmo_cnt_d     = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_busy) begin
      tmo_cnt_d = (tmo_cnt_q >= TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      if (tmo_cnt_d == TMO_MAX) mem_timeout_d = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      sav_state_q   <= RUN;
      sav_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sav_state_q   <= sav_state_d;
      sav_cnt_q     <= sav_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d, perf_flush_q, perf_flush_d, perf_mem_q, perf_mem_d;

  // A bubble without a flush can only come from a load-use stall.
  always_comb begin
    perf_lu_d    = perf_lu_q    + {31'd0, (bubble_EX && !flush_ID)};
    perf_flush_d = perf_flush_q + {31'd0, flush_ID};
    perf_mem_d   = perf_mem_q   + {31'd0, stall_EX};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
      perf_mem_q   <= '0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_flush_q <= perf_flush_d;
      perf_mem_q   <= perf_mem_d;
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_mem_cnt   = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_STALL_CYCLES=2, FLUSH_CYCLES=2, MEM_TIMEOUT=8).
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset, id_rs_used, id_rt_used, ex_mem_read, branch_taken, mem_busy;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       wait_ID, pc_wr_en, flush_ID, bubble_EX, stall_EX, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_mem_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .wait_ID(wait_ID), .pc_wr_en(pc_wr_en), .flush_ID(flush_ID),
    .bubble_EX(bubble_EX), .stall_EX(stall_EX), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_mem_cnt(perf_mem_cnt)
`endif
  );

  // {wait_ID, pc_wr_en, flush_ID, bubble_EX, stall_EX, mem_timeout}
  localparam logic [5:0] RUNV = 6'b010000;
  localparam logic [5:0] LUV  = 6'b100100;
  localparam logic [5:0] FLV  = 6'b011100;
  localparam logic [5:0] FZV  = 6'b100010;
  localparam logic [5:0] TO   = 6'b000001;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic cyc(input bit rst_n, input bit busy, input bit br, input bit mrd,
                     input logic [4:0] exrd, input logic [4:0] rs, input bit rsu,
                     input logic [4:0] rt, input bit rtu, input bit chk,
                     input logic [5:0] exp, input string tag);
    logic [5:0] obs, e;
    string      t;
    reset = rst_n; mem_busy = busy; branch_taken = br; ex_mem_read = mrd;
    ex_rd = exrd; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    if (chk) begin
      obs = {wait_ID, pc_wr_en, flush_ID, bubble_EX, stall_EX, mem_timeout};
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      n_assert++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
      n_assert++;
      assert (!(flush_ID && wait_ID) && !(stall_EX && bubble_EX)) else begin
        n_fail++;
        $error("FAIL %s_invariant observed=%b expected=no_conflict", t, obs);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [5:0] exp, input string tag);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, exp, tag);
  endtask
  task automatic luc(input logic [5:0] exp, input string tag);
    cyc(1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, exp, tag);
  endtask
  task automatic brc(input logic [5:0] exp, input string tag);
    cyc(1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, exp, tag);
  endtask
  task automatic busyc(input logic [5:0] exp, input string tag);
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, exp, tag);
  endtask
  task automatic rstc();
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, RUNV, "rst");
  endtask

  initial begin
    // reset held with busy and branch active
    cyc(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, RUNV, "rst0");
    cyc(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, RUNV, "rst1");
    idle(RUNV, "reset_run");

    // load-use on rs: exactly two stall cycles
    luc(LUV, "lu_rs_c1");
    idle(LUV, "lu_rs_c2");
    idle(RUNV, "lu_rs_done");
    // ex_rd==0 never stalls
    cyc(1, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 1, RUNV, "lu_rd0");
    // rt match only counts when rt is used
    cyc(1, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, 1, RUNV, "lu_rt_unused");
    cyc(1, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 1, LUV, "lu_rt_c1");
    idle(LUV, "lu_rt_c2");
    idle(RUNV, "lu_rt_done");
    // not a load
    cyc(1, 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 1, RUNV, "no_load");

    // taken branch: two flush cycles
    brc(FLV, "br_c1");
    idle(FLV, "br_c2");
    idle(RUNV, "br_done");
    // branch during LD_STALL cancels the stall
    luc(LUV, "brld_lu");
    brc(FLV, "brld_br");
    idle(FLV, "brld_fl2");
    idle(RUNV, "brld_done");
    // branch and load-use together: branch wins
    cyc(1, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, FLV, "brlu_c1");
    idle(FLV, "brlu_c2");
    idle(RUNV, "brlu_done");
    // branch in FLUSH restarts the count
    brc(FLV, "brfl_c1");
    brc(FLV, "brfl_c2");
    idle(FLV, "brfl_c3");
    idle(RUNV, "brfl_done");

    // freeze during FLUSH with one cycle left
    brc(FLV, "mfl_br");
    for (int i = 0; i < 4; i++) busyc(FZV, $sformatf("mfl_busy%0d", i));
    idle(FLV, "mfl_resume");
    idle(RUNV, "mfl_done");
    // freeze during LD_STALL resumes the stall
    luc(LUV, "mld_lu");
    busyc(FZV, "mld_busy0");
    busyc(FZV, "mld_busy1");
    idle(LUV, "mld_resume");
    idle(RUNV, "mld_done");

    // busy + branch + load-use: freeze only, and nothing left over afterwards
    cyc(1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, FZV, "simul");
    idle(RUNV, "simul_after");

    // busy count clears when busy drops
    for (int i = 0; i < 7; i++) busyc(FZV, $sformatf("tclr_a%0d", i));
    idle(RUNV, "tclr_gap");
    busyc(FZV, "tclr_b0");
    busyc(FZV, "tclr_b1");
    idle(RUNV, "tclr_done");

    // timeout after the 8th consecutive busy cycle, sticky until reset
    for (int i = 1; i <= 10; i++) busyc((i <= 8) ? FZV : (FZV | TO), $sformatf("tmo_busy%0d", i));
    idle(RUNV | TO, "tmo_sticky1");
    luc(LUV | TO, "tmo_sticky_lu");
    idle(LUV | TO, "tmo_sticky_ld");
    rstc();
    idle(RUNV, "tmo_cleared");

    // reset aborts stall, flush and wait
    luc(LUV, "rld_lu");
    rstc();
    idle(RUNV, "rld_after");
    brc(FLV, "rfl_br");
    rstc();
    idle(RUNV, "rfl_after");
    busyc(FZV, "rmw_busy");
    rstc();
    idle(RUNV, "rmw_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
